hashtable_bitmap_writer: RTL and testbench
==========================================

HASHTABLE_BITMAP_WRITER -- requirements
Module: hashtable_bitmap_writer

Interface
REQ-001 The block SHALL have parameter NBITS, default 15, meaning the hash address width.
REQ-002 The block SHALL have parameter BM_AWIDTH, default NBITS-3, meaning the bitmap word address width (8 bits per word).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-007 cmd_addr  input  NBITS  hash address; [NBITS-1:3] selects the word, [2:0] selects the bit.
REQ-008 cmd_op  input  2  operation: 00 SET, 01 CLEAR, 10 CLEAR_ALL, 11 QUERY.
REQ-009 resp_valid  output  1  one-cycle pulse marking completion of the accepted command.
REQ-010 resp_bit  output  1  prior value of the addressed bit (0 for CLEAR_ALL).
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 mem_rd_en / mem_rd_addr  output  1 / BM_AWIDTH  bitmap read port.
REQ-013 mem_rd_data  input  8  read data, valid exactly 2 cycles after mem_rd_en.
REQ-014 mem_wr_en / mem_wr_addr / mem_wr_data  output  1 / BM_AWIDTH / 8  bitmap write port.

Function
REQ-015 The FSM SHALL use states IDLE, RD, WAIT1, WAIT2, WR, and CLR.
REQ-016 cmd_ready SHALL be 1 only in IDLE; while busy, cmd_valid is ignored and no command is captured.
REQ-017 On acceptance at edge T, address and op SHALL be registered; SET/CLEAR/QUERY go to RD, CLEAR_ALL goes to CLR with the sweep counter at 0.
REQ-018 In RD (cycle T+1), mem_rd_en SHALL be 1 and mem_rd_addr SHALL be cmd_addr[NBITS-1:3]; next state WAIT1, then WAIT2.
REQ-019 At the WAIT2->WR edge (end of T+3), mem_rd_data SHALL be captured and the selected bit stored as resp_bit.
REQ-020 In WR (cycle T+4), SET/CLEAR SHALL assert mem_wr_en for exactly one cycle, with mem_wr_addr equal to the word address and mem_wr_data equal to the captured word with the selected bit forced to 1 (SET) or 0 (CLEAR), all other bits unchanged.
REQ-021 QUERY SHALL never assert mem_wr_en.
REQ-022 resp_valid SHALL pulse in cycle T+4 for SET/CLEAR/QUERY, and the next state SHALL be IDLE (next acceptance no earlier than T+5).
REQ-023 SET of a bit already 1, or CLEAR of a bit already 0, SHALL still write (unchanged data) and report the prior value on resp_bit.
REQ-024 In CLR, each cycle SHALL write mem_wr_data=0 to mem_wr_addr equal to the counter, then increment the counter; mem_rd_en SHALL stay 0.
REQ-025 After writing address 2^BM_AWIDTH-1, CLR SHALL pulse resp_valid with resp_bit=0 in that same cycle and return to IDLE; the counter SHALL NOT wrap into a second pass.
REQ-026 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-027 resp_bit SHALL hold its value between pulses.

Reset
REQ-028 While rst_n=0: state IDLE, cmd_ready=1 after release, busy=0, resp_valid=0, resp_bit=0, mem_rd_en=0, mem_wr_en=0, addresses/data 0, sweep counter 0.
REQ-029 Reset asserted mid-command or mid-sweep SHALL abort immediately with no further memory write; the partial sweep is not resumed.

Verification
REQ-030 SET addr 0x0013, word 2 initially 0x00 -> rd at T+1 addr 2; wr at T+4 addr 2 data 0x08; resp_bit=0.
REQ-031 CLEAR addr 0x0017, word 2 = 0xFF -> wr data 0x7F; resp_bit=1; the next command is accepted no earlier than T+5.
REQ-032 QUERY addr 0x7FFF, word 0xFFF = 0x80 -> resp_bit=1, resp_valid at T+4, no mem_wr_en.
REQ-033 CLEAR_ALL with NBITS=6 -> 8 consecutive writes of 0x00 to addrs 0..7, resp_valid with the last write, cmd_valid held high during the sweep is not accepted until IDLE.
REQ-034 Assert rst_n=0 during WAIT2 of a SET -> no mem_wr_en, busy=0; after release, a fresh SET completes normally.
REQ-035 Back-to-back SET then QUERY on the same bit -> QUERY reports resp_bit=1, reading the value written by the SET.

Source files
------------

// File: rtl/hashtable_bitmap_writer.sv
// Read-modify-write engine for a byte-wide hash-table occupancy bitmap.
// Supports single-bit SET/CLEAR/QUERY and a full-table CLEAR_ALL sweep.
module hashtable_bitmap_writer #(
    parameter int NBITS     = 15,
    parameter int BM_AWIDTH = NBITS - 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [NBITS-1:0]     i_cmd_addr,
    input  logic [1:0]           i_cmd_op,
    output logic                 o_resp_valid,
    output logic                 o_resp_bit,
    output logic                 o_busy,
    output logic                 o_mem_rd_en,
    output logic [BM_AWIDTH-1:0] o_mem_rd_addr,
    input  logic [7:0]           i_mem_rd_data,
    output logic                 o_mem_wr_en,
    output logic [BM_AWIDTH-1:0] o_mem_wr_addr,
    output logic [7:0]           o_mem_wr_data
);

    localparam logic [1:0] OP_SET       = 2'b00;
    localparam logic [1:0] OP_CLEAR     = 2'b01;
    localparam logic [1:0] OP_CLEAR_ALL = 2'b10;
    localparam logic [1:0] OP_QUERY     = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAIT1 = 3'd2,
        WAIT2 = 3'd3,
        WR    = 3'd4,
        CLR   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NBITS-1:0]       r_addr;
    logic [1:0]             r_op;
    logic [7:0]             r_word;
    logic                   r_resp_bit;
    logic [BM_AWIDTH-1:0]   r_cnt;

    logic [BM_AWIDTH-1:0]   w_word_addr;
    logic [2:0]             w_bit_sel;
    logic [7:0]             w_wr_word;
    logic                   w_sweep_last;

    function automatic logic [7:0] force_bit(input logic [7:0] word,
                                             input logic [2:0] idx,
                                             input logic       val);
        logic [7:0] res;
        res      = word;
        res[idx] = val;
        return res;
    endfunction

    assign w_word_addr  = r_addr[NBITS-1:3];
    assign w_bit_sel    = r_addr[2:0];
    assign w_wr_word    = force_bit(r_word, w_bit_sel, (r_op == OP_SET));
    assign w_sweep_last = (r_cnt == {BM_AWIDTH{1'b1}});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_op       <= OP_SET;
            r_word     <= '0;
            r_resp_bit <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr <= i_cmd_addr;
                        r_op   <= i_cmd_op;
                        r_cnt  <= '0;
                    end
                end
                WAIT2: begin
                    // Read data arrives two cycles after the RD strobe
                    r_word     <= i_mem_rd_data;
                    r_resp_bit <= i_mem_rd_data[w_bit_sel];
                end
                CLR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_sweep_last) begin
                        r_resp_bit <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_cmd_ready   = 1'b0;
        o_busy        = 1'b1;
        o_resp_valid  = 1'b0;
        o_resp_bit    = r_resp_bit;
        o_mem_rd_en   = 1'b0;
        o_mem_rd_addr = '0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_addr = '0;
        o_mem_wr_data = '0;
        case (r_state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_cmd_valid) begin
                    w_state_nxt = (i_cmd_op == OP_CLEAR_ALL) ? CLR : RD;
                end
            end
            RD: begin
                o_mem_rd_en   = 1'b1;
                o_mem_rd_addr = w_word_addr;
                w_state_nxt   = WAIT1;
            end
            WAIT1: begin
                w_state_nxt = WAIT2;
            end
            WAIT2: begin
                w_state_nxt = WR;
            end
            WR: begin
                o_resp_valid = 1'b1;
                // Writes happen even when the bit already holds the target value
                if (r_op == OP_SET || r_op == OP_CLEAR) begin
                    o_mem_wr_en   = 1'b1;
                    o_mem_wr_addr = w_word_addr;
                    o_mem_wr_data = w_wr_word;
                end
                w_state_nxt = IDLE;
            end
            CLR: begin
                o_mem_wr_en   = 1'b1;
                o_mem_wr_addr = r_cnt;
                o_mem_wr_data = 8'h00;
                if (w_sweep_last) begin
                    o_resp_valid = 1'b1;
                    o_resp_bit   = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hashtable_bitmap_writer.sv
// Directed bench for hashtable_bitmap_writer: a 15-bit instance against a
// 2-cycle-latency bitmap model, plus a 6-bit instance for the CLEAR_ALL sweep.
module tb_hashtable_bitmap_writer;

    localparam logic [1:0] OP_SET = 2'b00, OP_CLEAR = 2'b01, OP_CLEAR_ALL = 2'b10, OP_QUERY = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        cmd_valid, cmd_ready, resp_valid, resp_bit, busy;
    logic [14:0] cmd_addr;
    logic [1:0]  cmd_op;
    logic        rd_en, wr_en;
    logic [11:0] rd_addr, wr_addr;
    logic [7:0]  rd_data, wr_data;

    logic        cmd_valid6, cmd_ready6, resp_valid6, resp_bit6, busy6;
    logic [5:0]  cmd_addr6;
    logic [1:0]  cmd_op6;
    logic        rd_en6, wr_en6;
    logic [2:0]  rd_addr6, wr_addr6;
    logic [7:0]  rd_data6, wr_data6;
    assign rd_data6 = 8'hFF;

    hashtable_bitmap_writer #(.NBITS(15)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_addr(cmd_addr), .i_cmd_op(cmd_op), .o_resp_valid(resp_valid), .o_resp_bit(resp_bit),
        .o_busy(busy), .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr), .i_mem_rd_data(rd_data),
        .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr), .o_mem_wr_data(wr_data)
    );

    hashtable_bitmap_writer #(.NBITS(6)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid6), .o_cmd_ready(cmd_ready6),
        .i_cmd_addr(cmd_addr6), .i_cmd_op(cmd_op6), .o_resp_valid(resp_valid6), .o_resp_bit(resp_bit6),
        .o_busy(busy6), .o_mem_rd_en(rd_en6), .o_mem_rd_addr(rd_addr6), .i_mem_rd_data(rd_data6),
        .o_mem_wr_en(wr_en6), .o_mem_wr_addr(wr_addr6), .o_mem_wr_data(wr_data6)
    );

    // Bitmap model: read data appears two cycles after the strobe, poisoned otherwise
    logic [7:0]  mem [0:4095];
    logic [7:0]  s1 = 8'hEE, s2 = 8'hEE;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [7:0]  pl_data;
    int wr_count = 0, wr_count6 = 0, overlap_cnt = 0;

    always @(posedge clk) begin
        s1 <= rd_en ? mem[rd_addr] : 8'hEE;
        s2 <= s1;
        if (wr_en) mem[wr_addr] <= wr_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
        if (wr_en) wr_count <= wr_count + 1;
        if (wr_en6) wr_count6 <= wr_count6 + 1;
        if ((rd_en && wr_en) || (rd_en6 && wr_en6)) overlap_cnt <= overlap_cnt + 1;
    end
    assign rd_data = s2;

    int n_tests = 0, n_fail = 0;

    // Per-command observations captured by run_op
    logic        o_ready0, o_rd_en1, o_busy1, o_ready_mid, o_rv_early;
    logic [11:0] o_rd_addr1, o_wr_addr4;
    logic        o_wr_en4, o_rv4, o_rbit4, o_rv5, o_ready5, o_busy5, o_wr5;
    logic [7:0]  o_wr_data4;
    int          o_extra;

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one command from a negedge and samples every cycle up to T+5
    task automatic run_op(input logic [1:0] op, input logic [14:0] a, input bit hold);
        o_ready0 = cmd_ready;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        o_rd_en1 = rd_en; o_rd_addr1 = rd_addr; o_busy1 = busy;
        o_ready_mid = cmd_ready; o_rv_early = resp_valid; o_extra = int'(wr_en);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            o_extra = o_extra + int'(rd_en) + int'(wr_en);
            o_ready_mid = o_ready_mid | cmd_ready;
            o_rv_early = o_rv_early | resp_valid;
        end
        @(negedge clk);
        o_ready_mid = o_ready_mid | cmd_ready;
        o_extra = o_extra + int'(rd_en);
        o_wr_en4 = wr_en; o_wr_addr4 = wr_addr; o_wr_data4 = wr_data;
        o_rv4 = resp_valid; o_rbit4 = resp_bit;
        @(negedge clk);
        o_rv5 = resp_valid; o_ready5 = cmd_ready; o_busy5 = busy; o_wr5 = wr_en;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_tests++; if (resp_bit !== 1'b0) begin n_fail++; $display("FAIL reset_resp_bit: got %b want 0", resp_bit); end
        n_tests++; if ({rd_en, wr_en} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got %b want 00", {rd_en, wr_en}); end
        n_tests++; if ({rd_addr, wr_addr, wr_data} !== 32'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h want 0", {rd_addr, wr_addr, wr_data}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_tests++; if (busy6 !== 1'b0) begin n_fail++; $display("FAIL reset_busy6: got %b want 0", busy6); end
    endtask

    task automatic test_set();
        preload(12'd2, 8'h00);
        run_op(OP_SET, 15'h0013, 1'b0);
        n_tests++; if (o_ready0 !== 1'b1) begin n_fail++; $display("FAIL set_ready: got %b want 1", o_ready0); end
        n_tests++; if (o_rd_en1 !== 1'b1) begin n_fail++; $display("FAIL set_rd_en: got %b want 1", o_rd_en1); end
        n_tests++; if (o_rd_addr1 !== 12'd2) begin n_fail++; $display("FAIL set_rd_addr: got %h want 2", o_rd_addr1); end
        n_tests++; if (o_busy1 !== 1'b1) begin n_fail++; $display("FAIL set_busy: got %b want 1", o_busy1); end
        n_tests++; if (o_extra !== 0) begin n_fail++; $display("FAIL set_stray_mem: got %0d want 0", o_extra); end
        n_tests++; if (o_rv_early !== 1'b0) begin n_fail++; $display("FAIL set_early_resp: got %b want 0", o_rv_early); end
        n_tests++; if (o_wr_en4 !== 1'b1) begin n_fail++; $display("FAIL set_wr_en: got %b want 1", o_wr_en4); end
        n_tests++; if (o_wr_addr4 !== 12'd2) begin n_fail++; $display("FAIL set_wr_addr: got %h want 2", o_wr_addr4); end
        n_tests++; if (o_wr_data4 !== 8'h08) begin n_fail++; $display("FAIL set_wr_data: got %h want 08", o_wr_data4); end
        n_tests++; if ({o_rv4, o_rbit4} !== 2'b10) begin n_fail++; $display("FAIL set_resp: got %b want 10", {o_rv4, o_rbit4}); end
        n_tests++; if ({o_rv5, o_wr5, o_ready5, o_busy5} !== 4'b0010) begin n_fail++; $display("FAIL set_after: got %b want 0010", {o_rv5, o_wr5, o_ready5, o_busy5}); end
        n_tests++; if (mem[2] !== 8'h08) begin n_fail++; $display("FAIL set_mem: got %h want 08", mem[2]); end
    endtask

    task automatic test_clear();
        int wc0;
        preload(12'd2, 8'hFF);
        wc0 = wr_count;
        run_op(OP_CLEAR, 15'h0017, 1'b1);
        n_tests++; if (o_ready_mid !== 1'b0) begin n_fail++; $display("FAIL clear_ready_busy: got %b want 0", o_ready_mid); end
        n_tests++; if (o_wr_data4 !== 8'h7F) begin n_fail++; $display("FAIL clear_wr_data: got %h want 7f", o_wr_data4); end
        n_tests++; if ({o_wr_en4, o_rv4, o_rbit4} !== 3'b111) begin n_fail++; $display("FAIL clear_resp: got %b want 111", {o_wr_en4, o_rv4, o_rbit4}); end
        n_tests++; if (o_ready5 !== 1'b1) begin n_fail++; $display("FAIL clear_ready_t5: got %b want 1", o_ready5); end
        // The held request is taken at T+5: clearing an already-clear bit still writes
        run_op(OP_CLEAR, 15'h0017, 1'b0);
        n_tests++; if ({o_rd_en1, o_wr_en4, o_wr_data4} !== 10'b11_0111_1111) begin n_fail++; $display("FAIL clear_again_wr: got %b want 1101111111", {o_rd_en1, o_wr_en4, o_wr_data4}); end
        n_tests++; if ({o_rv4, o_rbit4} !== 2'b10) begin n_fail++; $display("FAIL clear_again_resp: got %b want 10", {o_rv4, o_rbit4}); end
        n_tests++; if (wr_count - wc0 !== 2) begin n_fail++; $display("FAIL clear_wr_count: got %0d want 2", wr_count - wc0); end
    endtask

    task automatic test_query();
        int wc0;
        preload(12'hFFF, 8'h80);
        wc0 = wr_count;
        run_op(OP_QUERY, 15'h7FFF, 1'b0);
        n_tests++; if (o_rd_addr1 !== 12'hFFF) begin n_fail++; $display("FAIL query_rd_addr: got %h want fff", o_rd_addr1); end
        n_tests++; if ({o_rv4, o_rbit4} !== 2'b11) begin n_fail++; $display("FAIL query_resp: got %b want 11", {o_rv4, o_rbit4}); end
        n_tests++; if (o_wr_en4 !== 1'b0) begin n_fail++; $display("FAIL query_wr_en: got %b want 0", o_wr_en4); end
        n_tests++; if (wr_count - wc0 !== 0) begin n_fail++; $display("FAIL query_wr_count: got %0d want 0", wr_count - wc0); end
        n_tests++; if (mem[12'hFFF] !== 8'h80) begin n_fail++; $display("FAIL query_mem: got %h want 80", mem[12'hFFF]); end
        n_tests++; if (o_rbit4 !== resp_bit || resp_valid !== 1'b0) begin n_fail++; $display("FAIL query_hold: got bit %b valid %b want 1 0", resp_bit, resp_valid); end
    endtask

    task automatic test_reset_abort();
        int wc0;
        preload(12'd5, 8'h00);
        wc0 = wr_count;
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_addr = 15'h0028;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if ({busy, wr_en} !== 2'b00) begin n_fail++; $display("FAIL abort_busy_wr: got %b want 00", {busy, wr_en}); end
        repeat (3) @(negedge clk);
        n_tests++; if (wr_count - wc0 !== 0) begin n_fail++; $display("FAIL abort_no_write: got %0d want 0", wr_count - wc0); end
        n_tests++; if (mem[5] !== 8'h00) begin n_fail++; $display("FAIL abort_mem: got %h want 00", mem[5]); end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(OP_SET, 15'h0028, 1'b0);
        n_tests++; if ({o_wr_en4, o_wr_addr4, o_wr_data4} !== {1'b1, 12'd5, 8'h01}) begin n_fail++; $display("FAIL abort_fresh_wr: got %b %h %h want 1 005 01", o_wr_en4, o_wr_addr4, o_wr_data4); end
        n_tests++; if ({o_rv4, o_rbit4} !== 2'b10) begin n_fail++; $display("FAIL abort_fresh_resp: got %b want 10", {o_rv4, o_rbit4}); end
    endtask

    task automatic test_back_to_back();
        preload(12'd9, 8'h00);
        run_op(OP_SET, 15'h004D, 1'b0);
        n_tests++; if (o_wr_data4 !== 8'h20) begin n_fail++; $display("FAIL b2b_set_data: got %h want 20", o_wr_data4); end
        run_op(OP_QUERY, 15'h004D, 1'b0);
        n_tests++; if (o_ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", o_ready0); end
        n_tests++; if ({o_rv4, o_rbit4, o_wr_en4} !== 3'b110) begin n_fail++; $display("FAIL b2b_query: got %b want 110", {o_rv4, o_rbit4, o_wr_en4}); end
    endtask

    task automatic test_clear_all();
        int wc0;
        // A QUERY first so resp_bit is 1 going into the sweep
        cmd_valid6 = 1'b1; cmd_op6 = OP_QUERY; cmd_addr6 = 6'h05;
        @(posedge clk);
        @(negedge clk);
        cmd_valid6 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if ({resp_valid6, resp_bit6} !== 2'b11) begin n_fail++; $display("FAIL ca_query_resp: got %b want 11", {resp_valid6, resp_bit6}); end
        @(negedge clk);
        n_tests++; if ({resp_valid6, resp_bit6, cmd_ready6} !== 3'b011) begin n_fail++; $display("FAIL ca_query_hold: got %b want 011", {resp_valid6, resp_bit6, cmd_ready6}); end
        wc0 = wr_count6;
        cmd_valid6 = 1'b1; cmd_op6 = OP_CLEAR_ALL; cmd_addr6 = 6'h00;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++; if ({wr_en6, rd_en6, wr_addr6, wr_data6} !== {1'b1, 1'b0, 3'(k), 8'h00}) begin n_fail++; $display("FAIL ca_write_%0d: got %b%b %h %h want 10 %h 00", k, wr_en6, rd_en6, wr_addr6, wr_data6, k); end
            n_tests++; if ({resp_valid6, resp_bit6, cmd_ready6} !== ((k == 7) ? 3'b100 : 3'b010)) begin n_fail++; $display("FAIL ca_resp_%0d: got %b want %b", k, {resp_valid6, resp_bit6, cmd_ready6}, (k == 7) ? 3'b100 : 3'b010); end
        end
        @(negedge clk);
        n_tests++; if ({cmd_ready6, wr_en6, resp_valid6, resp_bit6} !== 4'b1000) begin n_fail++; $display("FAIL ca_done: got %b want 1000", {cmd_ready6, wr_en6, resp_valid6, resp_bit6}); end
        n_tests++; if (wr_count6 - wc0 !== 8) begin n_fail++; $display("FAIL ca_wr_count: got %0d want 8", wr_count6 - wc0); end
        // The still-held request is taken only now that the sweep is over
        cmd_op6 = OP_QUERY;
        @(posedge clk);
        @(negedge clk);
        cmd_valid6 = 1'b0;
        n_tests++; if ({rd_en6, busy6} !== 2'b11) begin n_fail++; $display("FAIL ca_next_accept: got %b want 11", {rd_en6, busy6}); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = OP_SET; cmd_addr = '0;
        cmd_valid6 = 1'b0; cmd_op6 = OP_SET; cmd_addr6 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_set();
        test_clear();
        test_query();
        test_reset_abort();
        test_back_to_back();
        test_clear_all();
        n_tests++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", overlap_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
